game_state_controller: RTL and testbench

- Sequences the game session: idle, ready/respawn, play, death freeze, game over.
- Sits downstream of the game-logic top. It consumes pacman_is_dead and drives back the game-logic rst (respawn to reset positions) and a run enable.
- Tracks remaining lives for the display/HUD stage.
- All timing is counted in frame ticks, not raw clocks.

---
 rtl/game_state_controller_if.sv | 23 ++
 rtl/game_state_controller.sv | 133 +++++++++++++
 tb/tb_game_state_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/game_state_controller_if.sv
// Signal bundle between the game-logic top and the session sequencer.
// The controller attaches through the slave modport; the driving side uses master.
interface game_state_controller_if;
    logic       tick;
    logic       start_btn;
    logic       pacman_is_dead;
    logic       game_rst;
    logic       game_run;
    logic [2:0] lives;
    logic [2:0] state_out;
    logic       death_flash;
    logic       game_over;

    modport master (
        output tick, start_btn, pacman_is_dead,
        input  game_rst, game_run, lives, state_out, death_flash, game_over
    );

    modport slave (
        input  tick, start_btn, pacman_is_dead,
        output game_rst, game_run, lives, state_out, death_flash, game_over
    );
endinterface

// File: rtl/game_state_controller.sv
// Game session sequencer: IDLE -> READY -> PLAY -> DYING -> READY/GAME_OVER, timed in frame ticks.
// Optional pause (start button toggles PLAY/PAUSE) is enabled by defining GAME_PAUSE_EN.
module game_state_controller #(
    parameter int LIVES_INIT  = 3,
    parameter int READY_TICKS = 120,
    parameter int DEATH_TICKS = 90,
    parameter int FLASH_DIV   = 8
) (
    input  logic clk,
    input  logic rst,
    game_state_controller_if.slave bus
);
    localparam int MAX_TICKS = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READY     = 3'd1,
        S_PLAY      = 3'd2,
        S_DYING     = 3'd3,
        S_GAME_OVER = 3'd4
`ifdef GAME_PAUSE_EN
        , S_PAUSE   = 3'd5
`endif
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         lives_r, lives_d;
    logic               flash_r, flash_d;
    logic               game_rst_r, game_run_r, game_over_r;
    logic               start_q, start_armed, start_pe;

    // The button must be seen low once after reset before an edge counts,
    // so a button held through reset release does not start a game.
    assign start_pe = bus.start_btn & ~start_q & start_armed;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        lives_d = lives_r;
        flash_d = flash_r;
        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (start_pe) begin
                    state_d = S_READY;
                    lives_d = 3'(LIVES_INIT);
                    cnt_d   = '0;
                end
            end
            S_READY: begin
                if (bus.tick) begin
                    if (cnt == CNT_W'(READY_TICKS - 1)) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (bus.pacman_is_dead) begin
                    state_d = S_DYING;
                    lives_d = (lives_r == 3'd0) ? 3'd0 : lives_r - 3'd1;
                    cnt_d   = '0;
                    flash_d = 1'b0;
                end
`ifdef GAME_PAUSE_EN
                else if (start_pe) begin
                    state_d = S_PAUSE;
                end
`endif
            end
            S_DYING: begin
                if (bus.tick) begin
                    if (cnt == CNT_W'(DEATH_TICKS - 1)) begin
                        state_d = (lives_r == 3'd0) ? S_GAME_OVER : S_READY;
                        cnt_d   = '0;
                        flash_d = 1'b0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                        if ((32'(cnt) % FLASH_DIV) == FLASH_DIV - 1)
                            flash_d = ~flash_r;
                    end
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (start_pe)
                    state_d = S_PLAY;
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                flash_d = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lives_r     <= 3'd0;
            flash_r     <= 1'b0;
            game_rst_r  <= 1'b1;
            game_run_r  <= 1'b0;
            game_over_r <= 1'b0;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            lives_r     <= lives_d;
            flash_r     <= flash_d;
            game_rst_r  <= (state_d == S_IDLE) || (state_d == S_READY);
            game_run_r  <= (state_d == S_PLAY);
            game_over_r <= (state_d == S_GAME_OVER);
            start_q     <= bus.start_btn;
            if (!bus.start_btn)
                start_armed <= 1'b1;
        end
    end

    assign bus.state_out   = state;
    assign bus.lives       = lives_r;
    assign bus.death_flash = flash_r;
    assign bus.game_rst    = game_rst_r;
    assign bus.game_run    = game_run_r;
    assign bus.game_over   = game_over_r;
endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with LIVES_INIT=3, READY_TICKS=4, DEATH_TICKS=8, FLASH_DIV=2.
module tb_game_state_controller;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  game_state_controller_if bus();

  game_state_controller #(
    .LIVES_INIT (3),
    .READY_TICKS(4),
    .DEATH_TICKS(8),
    .FLASH_DIV  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- driver tasks ----------------
  task automatic do_tick();
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start_btn = 1'b1;
    @(negedge clk); bus.start_btn = 1'b0;
  endtask

  task automatic pulse_dead();
    @(negedge clk); bus.pacman_is_dead = 1'b1;
    @(negedge clk); bus.pacman_is_dead = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.tick = 1'b0; bus.start_btn = 1'b0; bus.pacman_is_dead = 1'b0;
    rst = 1'b0;
    #12;
    total++; if (bus.state_out !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", bus.state_out); end
    total++; if (bus.lives !== 3'd0) begin bad++; $display("FAIL rst_lives got=%0d want=0", bus.lives); end
    total++; if (bus.game_rst !== 1'b1) begin bad++; $display("FAIL rst_game_rst got=%b want=1", bus.game_rst); end
    total++; if (bus.game_run !== 1'b0) begin bad++; $display("FAIL rst_game_run got=%b want=0", bus.game_run); end
    total++; if (bus.death_flash !== 1'b0) begin bad++; $display("FAIL rst_flash got=%b want=0", bus.death_flash); end
    total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL rst_game_over got=%b want=0", bus.game_over); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start();
    pulse_start();
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL start_state got=%0d want=1", bus.state_out); end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL start_lives got=%0d want=3", bus.lives); end
    total++; if (bus.game_rst !== 1'b1) begin bad++; $display("FAIL start_game_rst got=%b want=1", bus.game_rst); end
    do_ticks(3);
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL ready3_state got=%0d want=1", bus.state_out); end
    do_tick();
    total++; if (bus.state_out !== 3'd2) begin bad++; $display("FAIL ready4_state got=%0d want=2", bus.state_out); end
    total++; if (bus.game_rst !== 1'b0) begin bad++; $display("FAIL play_game_rst got=%b want=0", bus.game_rst); end
    total++; if (bus.game_run !== 1'b1) begin bad++; $display("FAIL play_game_run got=%b want=1", bus.game_run); end
  endtask

  task automatic test_death();
    logic exp_flash [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_state;
    pulse_dead();
    total++; if (bus.state_out !== 3'd3) begin bad++; $display("FAIL death_state got=%0d want=3", bus.state_out); end
    total++; if (bus.lives !== 3'd2) begin bad++; $display("FAIL death_lives got=%0d want=2", bus.lives); end
    total++; if (bus.game_run !== 1'b0) begin bad++; $display("FAIL death_game_run got=%b want=0", bus.game_run); end
    total++; if (bus.game_rst !== 1'b0) begin bad++; $display("FAIL death_game_rst got=%b want=0", bus.game_rst); end
    total++; if (bus.death_flash !== 1'b0) begin bad++; $display("FAIL death_flash0 got=%b want=0", bus.death_flash); end
    for (int k = 0; k < 8; k++) begin
      do_tick();
      exp_state = (k == 7) ? 3'd1 : 3'd3;
      total++; if (bus.death_flash !== exp_flash[k]) begin bad++; $display("FAIL dying_flash tick=%0d got=%b want=%b", k + 1, bus.death_flash, exp_flash[k]); end
      total++; if (bus.state_out !== exp_state) begin bad++; $display("FAIL dying_state tick=%0d got=%0d want=%0d", k + 1, bus.state_out, exp_state); end
    end
    total++; if (bus.game_rst !== 1'b1) begin bad++; $display("FAIL respawn_game_rst got=%b want=1", bus.game_rst); end
    do_ticks(4);
    total++; if (bus.state_out !== 3'd2) begin bad++; $display("FAIL respawn_play got=%0d want=2", bus.state_out); end
  endtask

  task automatic test_game_over();
    pulse_dead(); do_ticks(8);
    total++; if (bus.lives !== 3'd1) begin bad++; $display("FAIL go_lives1 got=%0d want=1", bus.lives); end
    do_ticks(4);
    pulse_dead(); do_ticks(7);
    total++; if (bus.state_out !== 3'd3) begin bad++; $display("FAIL go_last_dying got=%0d want=3", bus.state_out); end
    do_tick();
    total++; if (bus.state_out !== 3'd4) begin bad++; $display("FAIL go_state got=%0d want=4", bus.state_out); end
    total++; if (bus.game_over !== 1'b1) begin bad++; $display("FAIL go_flag got=%b want=1", bus.game_over); end
    total++; if (bus.lives !== 3'd0) begin bad++; $display("FAIL go_lives0 got=%0d want=0", bus.lives); end
    total++; if (bus.game_rst !== 1'b0) begin bad++; $display("FAIL go_game_rst got=%b want=0", bus.game_rst); end
    pulse_start();
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL go_restart_state got=%0d want=1", bus.state_out); end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL go_restart_lives got=%0d want=3", bus.lives); end
    total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL go_restart_flag got=%b want=0", bus.game_over); end
  endtask

  task automatic test_ignore_dead();
    // READY with the collision flag held: only tick sequencing matters
    @(negedge clk); bus.pacman_is_dead = 1'b1;
    do_ticks(3);
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL ign_ready_state got=%0d want=1", bus.state_out); end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL ign_ready_lives got=%0d want=3", bus.lives); end
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0; bus.pacman_is_dead = 1'b0;
    total++; if (bus.state_out !== 3'd2) begin bad++; $display("FAIL ign_to_play got=%0d want=2", bus.state_out); end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL ign_play_lives got=%0d want=3", bus.lives); end
    // tick and death together: death wins, that tick is not counted
    @(negedge clk); bus.tick = 1'b1; bus.pacman_is_dead = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
    total++; if (bus.state_out !== 3'd3) begin bad++; $display("FAIL same_cyc_state got=%0d want=3", bus.state_out); end
    total++; if (bus.lives !== 3'd2) begin bad++; $display("FAIL same_cyc_lives got=%0d want=2", bus.lives); end
    do_ticks(7);
    total++; if (bus.state_out !== 3'd3) begin bad++; $display("FAIL ign_dying7 got=%0d want=3", bus.state_out); end
    total++; if (bus.lives !== 3'd2) begin bad++; $display("FAIL ign_dying_lives got=%0d want=2", bus.lives); end
    do_tick();
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL ign_dying8 got=%0d want=1", bus.state_out); end
    @(negedge clk); bus.pacman_is_dead = 1'b0;
    do_ticks(4);
    pulse_dead(); do_ticks(8); do_ticks(4);
    pulse_dead(); do_ticks(8);
    total++; if (bus.state_out !== 3'd4) begin bad++; $display("FAIL ign_go_state got=%0d want=4", bus.state_out); end
    @(negedge clk); bus.pacman_is_dead = 1'b1;
    do_ticks(3);
    total++; if (bus.state_out !== 3'd4) begin bad++; $display("FAIL ign_go_hold got=%0d want=4", bus.state_out); end
    total++; if (bus.lives !== 3'd0) begin bad++; $display("FAIL ign_go_lives got=%0d want=0", bus.lives); end
    @(negedge clk); bus.pacman_is_dead = 1'b0;
    // start and tick together: go to READY, tick not counted
    @(negedge clk); bus.start_btn = 1'b1; bus.tick = 1'b1;
    @(negedge clk); bus.start_btn = 1'b0; bus.tick = 1'b0;
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL st_tick_state got=%0d want=1", bus.state_out); end
    do_ticks(3);
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL st_tick_ready3 got=%0d want=1", bus.state_out); end
    do_tick();
    total++; if (bus.state_out !== 3'd2) begin bad++; $display("FAIL st_tick_play got=%0d want=2", bus.state_out); end
  endtask

  task automatic test_pause();
    pulse_start();
`ifdef GAME_PAUSE_EN
    total++; if (bus.state_out !== 3'd5) begin bad++; $display("FAIL pause_state got=%0d want=5", bus.state_out); end
    total++; if (bus.game_run !== 1'b0) begin bad++; $display("FAIL pause_run got=%b want=0", bus.game_run); end
    total++; if (bus.game_rst !== 1'b0) begin bad++; $display("FAIL pause_rst got=%b want=0", bus.game_rst); end
    @(negedge clk); bus.pacman_is_dead = 1'b1;
    do_ticks(10);
    @(negedge clk); bus.pacman_is_dead = 1'b0;
    total++; if (bus.state_out !== 3'd5) begin bad++; $display("FAIL pause_hold got=%0d want=5", bus.state_out); end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL pause_lives got=%0d want=3", bus.lives); end
`else
    total++; if (bus.state_out !== 3'd2) begin bad++; $display("FAIL nopause_state got=%0d want=2", bus.state_out); end
    total++; if (bus.game_run !== 1'b1) begin bad++; $display("FAIL nopause_run got=%b want=1", bus.game_run); end
    do_ticks(10);
`endif
    pulse_start();
    total++; if (bus.state_out !== 3'd2) begin bad++; $display("FAIL resume_state got=%0d want=2", bus.state_out); end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL resume_lives got=%0d want=3", bus.lives); end
    total++; if (bus.game_run !== 1'b1) begin bad++; $display("FAIL resume_run got=%b want=1", bus.game_run); end
  endtask

  task automatic test_reset_mid();
    pulse_dead(); do_ticks(5);
    total++; if (bus.state_out !== 3'd3) begin bad++; $display("FAIL mid_pre_state got=%0d want=3", bus.state_out); end
    bus.start_btn = 1'b1;
    #3 rst = 1'b0;
    #1;
    total++; if (bus.state_out !== 3'd0) begin bad++; $display("FAIL mid_rst_state got=%0d want=0", bus.state_out); end
    total++; if (bus.lives !== 3'd0) begin bad++; $display("FAIL mid_rst_lives got=%0d want=0", bus.lives); end
    total++; if (bus.game_rst !== 1'b1) begin bad++; $display("FAIL mid_rst_game_rst got=%b want=1", bus.game_rst); end
    total++; if (bus.death_flash !== 1'b0) begin bad++; $display("FAIL mid_rst_flash got=%b want=0", bus.death_flash); end
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (bus.state_out !== 3'd0) begin bad++; $display("FAIL held_btn_state got=%0d want=0", bus.state_out); end
    bus.start_btn = 1'b0;
    pulse_start();
    total++; if (bus.state_out !== 3'd1) begin bad++; $display("FAIL fresh_edge_state got=%0d want=1", bus.state_out); end
    total++; if (bus.lives !== 3'd3) begin bad++; $display("FAIL fresh_edge_lives got=%0d want=3", bus.lives); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_death();
    test_game_over();
    test_ignore_dead();
    test_pause();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
